// File: rtl/wb_conbus_rr_pkg.sv
// rtl/wb_conbus_rr_pkg.sv - shared bus widths, arbiter states and clog2 helper
package wb_conbus_rr_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // ceil(log2(value)); used for index and counter widths at elaboration
   function automatic int wb_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/wb_conbus_rr_arbiter.sv
// rtl/wb_conbus_rr_arbiter.sv - round-robin grant holder with IDLE/BUSY ownership FSM
module wb_conbus_rr_arbiter
   import wb_conbus_rr_pkg::*;
#(
   parameter int N_M   = 2,
   parameter int IDX_W = (N_M > 1) ? wb_clog2(N_M) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_M-1:0]   req_i,
   input  logic             release_i,
   output logic [N_M-1:0]   gnt_onehot_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o
);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   // first requester after the last owner: scan above last, then wrap from 0
   always_comb begin
      pick_any = 1'b0;
      pick_idx = '0;
      for (int i = 0; i < N_M; i++) begin
         if (!pick_any && req_i[i] && (i > int'(last_q))) begin
            pick_any = 1'b1;
            pick_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < N_M; i++) begin
         if (!pick_any && req_i[i]) begin
            pick_any = 1'b1;
            pick_idx = IDX_W'(i);
         end
      end
   end

   // ownership FSM: grant registered in IDLE, held in BUSY until owner drops cyc
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_BUSY;
               gnt_d   = pick_idx;
            end
         end
         ARB_BUSY: begin
            if (release_i) begin
               state_d = ARB_IDLE;
               last_d  = gnt_q;
            end
         end
      endcase
   end

   // state registers; last owner resets to N_M-1 so master 0 wins first
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         last_q  <= IDX_W'(N_M - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   // one-hot grant is empty whenever no owner holds the bus
   always_comb begin
      gnt_onehot_o = '0;
      for (int i = 0; i < N_M; i++) begin
         if ((state_q == ARB_BUSY) && (gnt_q == IDX_W'(i))) gnt_onehot_o[i] = 1'b1;
      end
   end

   assign gnt_idx_o   = gnt_q;
   assign gnt_valid_o = (state_q == ARB_BUSY);

endmodule

// File: rtl/wb_conbus_rr.sv
// rtl/wb_conbus_rr.sv - N-master M-slave Wishbone shared bus with RR arbitration, decode error and timeout
module wb_conbus_rr
   import wb_conbus_rr_pkg::*;
#(
   parameter int N_M      = 2,
   parameter int N_S      = 6,
   parameter int S_ADDR_W = 3,
   parameter logic [N_S*S_ADDR_W-1:0] S_ADDR_MAP =
      {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
   parameter int TIMEOUT  = 255
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic [N_M*WB_AW-1:0]   m_adr_i,
   input  logic [N_M*WB_DW-1:0]   m_dat_i,
   input  logic [N_M*WB_SW-1:0]   m_sel_i,
   input  logic [N_M-1:0]         m_we_i,
   input  logic [N_M-1:0]         m_cyc_i,
   input  logic [N_M-1:0]         m_stb_i,
   output logic [WB_DW-1:0]       m_dat_o,
   output logic [N_M-1:0]         m_ack_o,
   output logic [N_M-1:0]         m_err_o,
   output logic [WB_AW-1:0]       s_adr_o,
   output logic [WB_DW-1:0]       s_dat_o,
   output logic [WB_SW-1:0]       s_sel_o,
   output logic                   s_we_o,
   output logic [N_S-1:0]         s_cyc_o,
   output logic [N_S-1:0]         s_stb_o,
   input  logic [N_S*WB_DW-1:0]   s_dat_i,
   input  logic [N_S-1:0]         s_ack_i
);

   localparam int IDX_W = (N_M > 1) ? wb_clog2(N_M) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? wb_clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   logic [N_M-1:0]   gnt_oh;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             arb_release;
   logic             cyc_g, stb_g, we_g;
   logic [WB_AW-1:0] adr_g;
   logic [WB_DW-1:0] dat_g;
   logic [WB_SW-1:0] sel_g;
   logic [N_S-1:0]   hit;
   logic             hit_any;
   logic             ack_sel;
   logic [WB_DW-1:0] dat_sel;
   logic             ack_g;
   logic             to_reach;
   logic             err_d, err_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign cyc_g       = gnt_valid & m_cyc_i[gnt_idx];
   assign stb_g       = cyc_g & m_stb_i[gnt_idx];
   assign arb_release = gnt_valid & ~m_cyc_i[gnt_idx];

   wb_conbus_rr_arbiter #(
      .N_M   (N_M),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk_i        (sys_clk),
      .rst_i        (sys_rst),
      .req_i        (m_cyc_i),
      .release_i    (arb_release),
      .gnt_onehot_o (gnt_oh),
      .gnt_idx_o    (gnt_idx),
      .gnt_valid_o  (gnt_valid)
   );

   // granted master's request fields; all zero while nobody owns the bus
   always_comb begin
      adr_g = '0;
      dat_g = '0;
      sel_g = '0;
      we_g  = 1'b0;
      for (int i = 0; i < N_M; i++) begin
         adr_g = adr_g | (m_adr_i[i*WB_AW +: WB_AW] & {WB_AW{gnt_oh[i]}});
         dat_g = dat_g | (m_dat_i[i*WB_DW +: WB_DW] & {WB_DW{gnt_oh[i]}});
         sel_g = sel_g | (m_sel_i[i*WB_SW +: WB_SW] & {WB_SW{gnt_oh[i]}});
         we_g  = we_g  | (m_we_i[i] & gnt_oh[i]);
      end
   end

   // top-bit decode, lowest matching map entry wins
   always_comb begin
      hit     = '0;
      hit_any = 1'b0;
      for (int k = 0; k < N_S; k++) begin
         if (gnt_valid && !hit_any &&
             (adr_g[WB_AW-1 -: S_ADDR_W] == S_ADDR_MAP[k*S_ADDR_W +: S_ADDR_W])) begin
            hit[k]  = 1'b1;
            hit_any = 1'b1;
         end
      end
   end

   // response mux from the decoded slave; zero data on no hit
   always_comb begin
      ack_sel = 1'b0;
      dat_sel = '0;
      for (int k = 0; k < N_S; k++) begin
         ack_sel = ack_sel | (s_ack_i[k] & hit[k]);
         dat_sel = dat_sel | (s_dat_i[k*WB_DW +: WB_DW] & {WB_DW{hit[k]}});
      end
   end

   assign ack_g    = stb_g & ack_sel;
   assign to_reach = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

   // err on unmapped strobe or on the count reaching TIMEOUT; an err cycle ends
   // the transfer, and a same-cycle ack always beats a pending err
   always_comb begin
      err_d = stb_g & ~ack_g & ~err_q & (~hit_any | to_reach);
      if (!stb_g || ack_g || err_d || to_reach) cnt_d = '0;
      else                                      cnt_d = cnt_q + 1'b1;
   end

   // error flag and ack-timeout counter
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign s_adr_o = adr_g;
   assign s_dat_o = dat_g;
   assign s_sel_o = sel_g;
   assign s_we_o  = we_g;
   assign s_cyc_o = hit & {N_S{cyc_g}};
   assign s_stb_o = hit & {N_S{stb_g & ~err_q}};
   assign m_dat_o = dat_sel;
   assign m_ack_o = gnt_oh & {N_M{ack_g}};
   assign m_err_o = gnt_oh & {N_M{err_q & ~ack_g}};

endmodule

// File: tb/tb_wb_conbus_rr.sv
// tb/tb_wb_conbus_rr.sv - directed self-checking bench for wb_conbus_rr
module tb_wb_conbus_rr;

   localparam int N_M = 2;
   localparam int N_S = 6;

   logic                sys_clk = 1'b0;
   logic                sys_rst;
   logic [N_M*32-1:0]   m_adr_i, m_dat_i;
   logic [N_M*4-1:0]    m_sel_i;
   logic [N_M-1:0]      m_we_i, m_cyc_i, m_stb_i;
   logic [31:0]         m_dat_o;
   logic [N_M-1:0]      m_ack_o, m_err_o;
   logic [31:0]         s_adr_o, s_dat_o;
   logic [3:0]          s_sel_o;
   logic                s_we_o;
   logic [N_S-1:0]      s_cyc_o, s_stb_o, s_ack_i, man_ack;
   logic [N_S*32-1:0]   s_dat_i;
   logic                auto_ack;
   int                  checks = 0;
   int                  failures = 0;

   always #5 sys_clk = ~sys_clk;

   assign s_ack_i = auto_ack ? s_stb_o : man_ack;

   wb_conbus_rr #(.N_M(N_M), .N_S(N_S), .TIMEOUT(8)) dut (
      .sys_clk (sys_clk), .sys_rst (sys_rst),
      .m_adr_i (m_adr_i), .m_dat_i (m_dat_i), .m_sel_i (m_sel_i),
      .m_we_i  (m_we_i),  .m_cyc_i (m_cyc_i), .m_stb_i (m_stb_i),
      .m_dat_o (m_dat_o), .m_ack_o (m_ack_o), .m_err_o (m_err_o),
      .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o), .s_we_o (s_we_o),
      .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_dat_i (s_dat_i), .s_ack_i (s_ack_i)
   );

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_inputs;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
      m_cyc_i = '0; m_stb_i = '0; man_ack = '0; auto_ack = 1'b0;
   endtask

   task automatic do_reset;
      clear_inputs();
      sys_rst = 1'b1;
      tick(); tick();
      sys_rst = 1'b0;
   endtask

   task automatic test_reset;
      sys_rst = 1'b1;
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      m_adr_i = {32'h8000_0000, 32'h0000_0010};
      man_ack = '1;
      tick(); tick();
      #2;
      checks++; if (s_cyc_o !== 6'b0) begin failures++; $display("FAIL reset_s_cyc got=%b exp=%b", s_cyc_o, 6'b0); end
      checks++; if (s_stb_o !== 6'b0) begin failures++; $display("FAIL reset_s_stb got=%b exp=%b", s_stb_o, 6'b0); end
      checks++; if (m_ack_o !== 2'b0) begin failures++; $display("FAIL reset_m_ack got=%b exp=%b", m_ack_o, 2'b0); end
      checks++; if (m_err_o !== 2'b0) begin failures++; $display("FAIL reset_m_err got=%b exp=%b", m_err_o, 2'b0); end
      checks++; if (m_dat_o !== 32'h0) begin failures++; $display("FAIL reset_m_dat got=%h exp=%h", m_dat_o, 32'h0); end
      checks++; if (s_adr_o !== 32'h0) begin failures++; $display("FAIL reset_s_adr got=%h exp=%h", s_adr_o, 32'h0); end
   endtask

   task automatic test_read;
      do_reset();
      m_adr_i = {32'h0, 32'h4000_0004}; m_sel_i = 8'h0F;
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      #2;
      checks++; if (s_stb_o !== 6'b0) begin failures++; $display("FAIL read_arb_cycle_stb got=%b exp=%b", s_stb_o, 6'b0); end
      tick(); #2;
      checks++; if (s_stb_o !== 6'b000010) begin failures++; $display("FAIL read_s_stb got=%b exp=%b", s_stb_o, 6'b000010); end
      checks++; if (s_cyc_o !== 6'b000010) begin failures++; $display("FAIL read_s_cyc got=%b exp=%b", s_cyc_o, 6'b000010); end
      checks++; if (s_adr_o !== 32'h4000_0004) begin failures++; $display("FAIL read_s_adr got=%h exp=%h", s_adr_o, 32'h4000_0004); end
      checks++; if (s_sel_o !== 4'hF) begin failures++; $display("FAIL read_s_sel got=%h exp=%h", s_sel_o, 4'hF); end
      checks++; if (m_ack_o !== 2'b00) begin failures++; $display("FAIL read_early_ack got=%b exp=%b", m_ack_o, 2'b00); end
      tick(); #2;
      checks++; if (m_ack_o !== 2'b00) begin failures++; $display("FAIL read_wait_ack got=%b exp=%b", m_ack_o, 2'b00); end
      tick();
      man_ack = 6'b000010;
      #2;
      checks++; if (m_ack_o !== 2'b01) begin failures++; $display("FAIL read_ack got=%b exp=%b", m_ack_o, 2'b01); end
      checks++; if (m_dat_o !== 32'h5D00_0001) begin failures++; $display("FAIL read_dat got=%h exp=%h", m_dat_o, 32'h5D00_0001); end
      checks++; if (m_err_o !== 2'b00) begin failures++; $display("FAIL read_err got=%b exp=%b", m_err_o, 2'b00); end
      tick();
      m_cyc_i = '0; m_stb_i = '0; man_ack = '0;
      #2;
      checks++; if (s_cyc_o !== 6'b0) begin failures++; $display("FAIL read_release_cyc got=%b exp=%b", s_cyc_o, 6'b0); end
   endtask

   task automatic test_round_robin;
      int          done0, done1;
      logic [1:0]  prev_ack, exp_ack;
      logic [5:0]  exp_cyc;
      do_reset();
      m_adr_i = {32'h8000_0000, 32'h4000_0000};
      auto_ack = 1'b1;
      done0 = 0; done1 = 0; prev_ack = 2'b00;
      for (int c = 0; c < 18; c++) begin
         m_cyc_i[0] = (done0 < 3) && !prev_ack[0];
         m_cyc_i[1] = (done1 < 3) && !prev_ack[1];
         m_stb_i = m_cyc_i;
         #2;
         exp_ack = (c % 3 == 1) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         exp_cyc = (c % 3 == 1) ? (((c / 3) % 2 == 0) ? 6'b000010 : 6'b001000) : 6'b000000;
         checks++; if (m_ack_o !== exp_ack) begin failures++; $display("FAIL rr_ack cycle=%0d got=%b exp=%b", c, m_ack_o, exp_ack); end
         checks++; if (s_cyc_o !== exp_cyc) begin failures++; $display("FAIL rr_s_cyc cycle=%0d got=%b exp=%b", c, s_cyc_o, exp_cyc); end
         if (m_ack_o[0] === 1'b1) done0++;
         if (m_ack_o[1] === 1'b1) done1++;
         prev_ack = m_ack_o;
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_unmapped;
      logic [1:0] exp_err;
      do_reset();
      m_adr_i = {32'hE000_0000, 32'h0};
      m_cyc_i = 2'b10; m_stb_i = 2'b10;
      for (int c = 0; c < 6; c++) begin
         if (c == 5) m_stb_i = 2'b00;
         #2;
         exp_err = (c == 2 || c == 4) ? 2'b10 : 2'b00;
         checks++; if (m_err_o !== exp_err) begin failures++; $display("FAIL unmapped_err cycle=%0d got=%b exp=%b", c, m_err_o, exp_err); end
         checks++; if (s_cyc_o !== 6'b0) begin failures++; $display("FAIL unmapped_s_cyc cycle=%0d got=%b exp=%b", c, s_cyc_o, 6'b0); end
         checks++; if (m_ack_o !== 2'b00) begin failures++; $display("FAIL unmapped_ack cycle=%0d got=%b exp=%b", c, m_ack_o, 2'b00); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_timeout;
      logic [1:0] exp_err;
      logic [5:0] exp_stb;
      do_reset();
      m_adr_i = {32'h0, 32'h8000_0000};
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      for (int c = 0; c < 19; c++) begin
         #2;
         exp_err = (c == 9 || c == 17) ? 2'b01 : 2'b00;
         exp_stb = (c >= 1 && c != 9 && c != 17) ? 6'b001000 : 6'b000000;
         checks++; if (m_err_o !== exp_err) begin failures++; $display("FAIL timeout_err cycle=%0d got=%b exp=%b", c, m_err_o, exp_err); end
         checks++; if (s_stb_o !== exp_stb) begin failures++; $display("FAIL timeout_s_stb cycle=%0d got=%b exp=%b", c, s_stb_o, exp_stb); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_ack_vs_timeout;
      logic [1:0] exp_err, exp_ack;
      do_reset();
      m_adr_i = {32'h0, 32'h8000_0000};
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      for (int c = 0; c < 18; c++) begin
         man_ack = (c == 8) ? 6'b001000 : 6'b000000;
         #2;
         exp_ack = (c == 8) ? 2'b01 : 2'b00;
         exp_err = (c == 17) ? 2'b01 : 2'b00;
         checks++; if (m_ack_o !== exp_ack) begin failures++; $display("FAIL ackto_ack cycle=%0d got=%b exp=%b", c, m_ack_o, exp_ack); end
         checks++; if (m_err_o !== exp_err) begin failures++; $display("FAIL ackto_err cycle=%0d got=%b exp=%b", c, m_err_o, exp_err); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid;
      do_reset();
      m_adr_i = {32'h8000_0000, 32'h0000_1000};
      m_dat_i = {32'h0, 32'hDEAD_BEEF};
      m_sel_i = 8'h0F; m_we_i = 2'b01;
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick(); #2;
      checks++; if (s_stb_o !== 6'b000001) begin failures++; $display("FAIL mid_s_stb got=%b exp=%b", s_stb_o, 6'b000001); end
      checks++; if (s_we_o !== 1'b1) begin failures++; $display("FAIL mid_s_we got=%b exp=%b", s_we_o, 1'b1); end
      checks++; if (s_dat_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mid_s_dat got=%h exp=%h", s_dat_o, 32'hDEAD_BEEF); end
      tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b11;
      man_ack = '1;
      #2;
      checks++; if (s_cyc_o !== 6'b0) begin failures++; $display("FAIL mid_rst_s_cyc got=%b exp=%b", s_cyc_o, 6'b0); end
      checks++; if (s_stb_o !== 6'b0) begin failures++; $display("FAIL mid_rst_s_stb got=%b exp=%b", s_stb_o, 6'b0); end
      checks++; if (s_we_o !== 1'b0) begin failures++; $display("FAIL mid_rst_s_we got=%b exp=%b", s_we_o, 1'b0); end
      checks++; if (s_dat_o !== 32'h0) begin failures++; $display("FAIL mid_rst_s_dat got=%h exp=%h", s_dat_o, 32'h0); end
      checks++; if (m_ack_o !== 2'b00) begin failures++; $display("FAIL mid_rst_ack got=%b exp=%b", m_ack_o, 2'b00); end
      checks++; if (m_err_o !== 2'b00) begin failures++; $display("FAIL mid_rst_err got=%b exp=%b", m_err_o, 2'b00); end
      tick(); #2;
      checks++; if (s_adr_o !== 32'h0000_1000) begin failures++; $display("FAIL mid_first_owner_adr got=%h exp=%h", s_adr_o, 32'h0000_1000); end
      checks++; if (m_ack_o !== 2'b01) begin failures++; $display("FAIL mid_first_owner_ack got=%b exp=%b", m_ack_o, 2'b01); end
      checks++; if (m_err_o !== 2'b00) begin failures++; $display("FAIL mid_first_owner_err got=%b exp=%b", m_err_o, 2'b00); end
      tick();
      clear_inputs();
   endtask

   initial begin
      for (int k = 0; k < N_S; k++) s_dat_i[k*32 +: 32] = 32'h5D00_0000 + 32'(k);
      clear_inputs();
      sys_rst = 1'b1;
      test_reset();
      test_read();
      test_round_robin();
      test_unmapped();
      test_timeout();
      test_ack_vs_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
